// File: rtl/serial_rca_if.sv
// Operand/result bus for serial_rca. The sub field exists only when
// SERIAL_RCA_SUB_EN is defined.
interface serial_rca_if #(
  parameter int WIDTH = 8
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // A producer holds valid and its payload until that edge. Ready never depends
  // on valid, and a producer never withdraws valid once it is raised.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_RCA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_RCA_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_RCA_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_rca.sv
// Digit-serial ripple-carry adder: DIGIT bits per clock, LSB digit first.
// Define SERIAL_RCA_SUB_EN to add a subtract mode (a + ~b + 1, cin ignored).
module serial_rca #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  serial_rca_if.slave bus,
  output logic [1:0]  dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_rca: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             last_dig;
  int unsigned      dig_lo;
`ifdef SERIAL_RCA_SUB_EN
  logic             sub_r;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last_dig)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    dbg_state     = state;
  end

  // One digit of the ripple chain; b is inverted here in subtract mode.
  always_comb begin
    dig_lo   = int'(cnt) * DIGIT;
    a_dig    = a_r[dig_lo +: DIGIT];
`ifdef SERIAL_RCA_SUB_EN
    b_dig    = b_r[dig_lo +: DIGIT] ^ {DIGIT{sub_r}};
`else
    b_dig    = b_r[dig_lo +: DIGIT];
`endif
    dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    last_dig = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef SERIAL_RCA_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
            cnt <= '0;
`ifdef SERIAL_RCA_SUB_EN
            sub_r <= bus.sub;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            carry <= bus.cin;
`endif
          end
        end
        RUN: begin
          sum_r[dig_lo +: DIGIT] <= dig_sum[DIGIT-1:0];
          carry                  <= dig_sum[DIGIT];
          if (last_dig) cout_r <= dig_sum[DIGIT];
          else          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_rca.sv
// Bench for serial_rca: an 8-bit/2-bit-digit instance and a 16-bit single-digit
// instance, checked against arithmetic reference values held in a queue.
module tb_serial_rca;

  logic clk;
  logic rst;
  logic [1:0] st8;
  logic [1:0] st16;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  serial_rca_if #(.WIDTH(8))  i8 ();
  serial_rca_if #(.WIDTH(16)) i16 ();

  serial_rca #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (i8.slave),
    .dbg_state (st8)
  );

  serial_rca #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .bus       (i16.slave),
    .dbg_state (st16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [31:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic s);
    int unsigned r;
    if (s) r = int'(a) + int'(8'(~b)) + 1;
    else   r = int'(a) + int'(b) + int'(cin);
    return r & 32'h1FF;
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    int unsigned r;
    r = int'(a) + int'(b) + int'(cin);
    return r & 32'h1FFFF;
  endfunction

  // Drivers
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic s, input int bp);
    int lat;
    logic [31:0] e;
    check("rdy8", 32'(i8.in_ready), 32'd1);
    i8.a = a;
    i8.b = b;
    i8.cin = cin;
`ifdef SERIAL_RCA_SUB_EN
    i8.sub = s;
`endif
    i8.in_valid = 1'b1;
    exp_q.push_back(model8(a, b, cin, s));
    step();
    i8.in_valid = 1'b0;
    i8.a = 8'($urandom);
    i8.b = 8'($urandom);
    i8.cin = 1'($urandom);
`ifdef SERIAL_RCA_SUB_EN
    i8.sub = 1'($urandom);
`endif
    lat = 0;
    while (!i8.out_valid && lat < 20) begin
      check("busy8", 32'(i8.in_ready), 32'd0);
      step();
      lat++;
    end
    check("lat8", 32'(lat), 32'd4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
    check("res8", 32'({i8.cout, i8.sum}), e);
    for (int i = 0; i < bp; i++) begin
      step();
      check("hold8", 32'({i8.cout, i8.sum}), e);
      check("ovhold8", 32'(i8.out_valid), 32'd1);
      check("bprdy8", 32'(i8.in_ready), 32'd0);
    end
    i8.out_ready = 1'b1;
    step();
    i8.out_ready = 1'b0;
    check("ovdrop8", 32'(i8.out_valid), 32'd0);
    check("rdyback8", 32'(i8.in_ready), 32'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input int bp);
    int lat;
    logic [31:0] e;
    check("rdy16", 32'(i16.in_ready), 32'd1);
    i16.a = a;
    i16.b = b;
    i16.cin = cin;
    i16.in_valid = 1'b1;
    exp_q.push_back(model16(a, b, cin));
    step();
    i16.in_valid = 1'b0;
    i16.a = 16'($urandom);
    i16.b = 16'($urandom);
    lat = 0;
    while (!i16.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("lat16", 32'(lat), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
    check("res16", 32'({i16.cout, i16.sum}), e);
    for (int i = 0; i < bp; i++) begin
      step();
      check("hold16", 32'({i16.cout, i16.sum}), e);
    end
    i16.out_ready = 1'b1;
    step();
    i16.out_ready = 1'b0;
    check("ovdrop16", 32'(i16.out_valid), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    i8.in_valid = 1'b0;  i8.a = '0;  i8.b = '0;  i8.cin = 1'b0;  i8.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0; i16.out_ready = 1'b0;
`ifdef SERIAL_RCA_SUB_EN
    i8.sub = 1'b0;
    i16.sub = 1'b0;
`endif
    repeat (3) step();
    check("rst_sum", 32'(i8.sum), 32'd0);
    check("rst_cout", 32'(i8.cout), 32'd0);
    check("rst_ov", 32'(i8.out_valid), 32'd0);
    check("rst_state", 32'(st8), 32'd0);
    rst = 1'b0;
    check("rel_rdy", 32'(i8.in_ready), 32'd1);
    step();

    // Directed cases
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    op8(8'h5A, 8'h3C, 1'b1, 1'b0, 5);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1);
    op8(8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Reset in the second RUN cycle discards the operation
    i8.a = 8'hAA; i8.b = 8'h55; i8.cin = 1'b0; i8.in_valid = 1'b1;
    step();
    i8.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_ov", 32'(i8.out_valid), 32'd0);
    check("mrst_sum", 32'(i8.sum), 32'd0);
    check("mrst_state", 32'(st8), 32'd0);
    check("mrst_rdy", 32'(i8.in_ready), 32'd1);
    op8(8'h01, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_RCA_SUB_EN
    op8(8'h05, 8'h07, 1'b1, 1'b1, 0);
    op8(8'h07, 8'h05, 1'b0, 1'b1, 2);
`endif

    // Random operations with random backpressure
    for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_RCA_SUB_EN
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
`else
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 3));
`endif
    end

    // Single-digit instance
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1);
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 1));

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got no end, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/serial_rca.md
SERIAL_RCA -- requirements
Module: serial_rca

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be at least 1.
REQ-002 Parameter DIGIT, default 2, bits added per clock; SHALL divide WIDTH exactly (N = WIDTH/DIGIT digit steps).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands a, b and cin are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry in.
REQ-010 out_valid  output  1  sum and cout are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result bits, LSB = bit 0.
REQ-013 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 The block SHALL have a 3-state FSM: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be decoded from state.
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; on accept the block SHALL register a, b and cin into working registers, clear the digit counter to 0 and enter RUN.
REQ-017 In each RUN cycle the block SHALL add digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of a and b plus the carry register, ripple-style, LSB first; it SHALL write the DIGIT result bits into sum at the same position and the digit carry-out into the carry register.
REQ-018 After digit N-1 the block SHALL enter DONE with cout equal to the final carry; sum and cout SHALL be bit-exact to (a + b + cin) mod 2^(WIDTH+1).
REQ-019 Latency: if accept occurs at edge T, out_valid SHALL first be 1 after edge T+N; with N=1 this is the cycle after accept.
REQ-020 In DONE, sum and cout SHALL hold stable while out_ready=0 (unbounded backpressure).
REQ-021 In DONE with out_ready=1 the block SHALL return to IDLE on that edge; no accept is possible in the same cycle, so back-to-back throughput is one operation per N+2 cycles.
REQ-022 Changes on a, b, cin or in_valid outside the accept edge SHALL NOT affect a result in progress.
REQ-023 sum and cout SHALL keep their last values in IDLE and RUN until overwritten; consumers qualify them with out_valid only.
REQ-024 All-ones overflow (a = b = 2^WIDTH-1, cin=1) SHALL produce sum = 2^WIDTH-1 and cout=1 with no other effect.

Reset
REQ-025 With rst=1 at an edge, the FSM SHALL enter IDLE and the counter, carry register, sum and cout SHALL become 0, from any state.
REQ-026 Reset mid-RUN or in DONE SHALL discard the operation; out_valid SHALL be 0 from the next cycle, and no partial result SHALL be presented.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro SERIAL_RCA_SUB_EN: when defined, the block SHALL add an input port sub (1 bit) that is registered on accept.
- With sub=1 the block SHALL compute a + ~b + 1, and cin SHALL be ignored.
- In that mode cout=1 means no borrow.
- With sub=0 the behaviour SHALL be identical to REQ-018.
REQ-029 When SERIAL_RCA_SUB_EN is undefined, the sub port SHALL NOT exist and the behaviour SHALL be add-only.

Verification
REQ-030 WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid first 1 four cycles after accept.
REQ-031 WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, cin=1, out_ready held 0 for 5 cycles -> sum=0x97, cout=0 stable throughout; in_ready=0 until the cycle after the out handshake.
REQ-032 Reset asserted in the second RUN cycle of a=0xAA+b=0x55 -> next cycle IDLE, out_valid=0, sum=0x00; a following 0x01+0x01 gives sum=0x02.
REQ-033 WIDTH=16, DIGIT=16 (N=1) with 1000 random operand pairs -> every result matches a reference model, each with latency 1.
REQ-034 SERIAL_RCA_SUB_EN defined, WIDTH=8: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
